// File: rtl/instr_word_encoder.sv
// Instruction word encoder: assembles RV32I R/load/store/branch words from
// field inputs, queues them in a small FIFO, and streams each word out with a
// sequential byte address for the instruction-memory loader.
module instr_word_encoder #(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [1:0]                       ins_type,
  input  logic [4:0]                       rd,
  input  logic [4:0]                       rs1,
  input  logic [4:0]                       rs2,
  input  logic [2:0]                       funct3,
  input  logic [6:0]                       funct7,
  input  logic [12:0]                      imm,
  input  logic                             err_clr,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [31:0]                      out_instr,
  output logic [ADDR_W-1:0]                out_addr,
  output logic [$clog2(DEPTH+1)-1:0]       count,
  output logic                             err
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    T_R = 2'b00,
    T_L = 2'b01,
    T_S = 2'b10,
    T_B = 2'b11
  } ins_t;

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   word;
  logic          legal;
  logic          accept, push, pop;

  // Field packing and legality check for the selected instruction class
  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (ins_t'(ins_type))
      T_R: word = {funct7, rs2, rs1, funct3, rd, 7'b0110011};
      T_L: begin
        word  = {imm[11:0], rs1, funct3, rd, 7'b0000011};
        legal = (imm[12] == imm[11]);
      end
      T_S: begin
        word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011};
        legal = (imm[12] == imm[11]);
      end
      T_B: begin
        word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011};
        legal = ~imm[0];
      end
      default: ;
    endcase
  end

  // in_ready depends only on occupancy, so a pop never admits a push when full
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign out_instr = out_valid ? mem[rd_ptr] : '0;
  assign accept    = in_valid & in_ready;
  assign push      = accept & legal;
  assign pop       = out_valid & out_ready;

  // Storage array; contents are don't-care until the matching push
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word;
  end

  // Pointers, occupancy, head address and sticky error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      out_addr <= ADDR_W'(BASE_ADDR);
      err      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + PW'(1);
        out_addr <= out_addr + ADDR_W'(4);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      // a rejection in the same cycle as a clear wins, so nothing is lost
      if (accept && !legal) err <= 1'b1;
      else if (err_clr)     err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_word_encoder.sv
// Directed bench for instr_word_encoder: encodings, FIFO flow control,
// illegal-immediate rejection, address wrap and mid-stream reset.
module tb_instr_word_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_valid2;
  logic        in_ready, in_ready2;
  logic [1:0]  ins_type;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [12:0] imm;
  logic        err_clr;
  logic        out_valid, out_valid2;
  logic        out_ready, out_ready2;
  logic [31:0] out_instr, out_instr2;
  logic [9:0]  out_addr;
  logic [3:0]  out_addr2;
  logic [2:0]  count, count2;
  logic        err, err2;

  int n_tests = 0;
  int n_fail  = 0;

  instr_word_encoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ins_type(ins_type), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .imm(imm), .err_clr(err_clr), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .count(count), .err(err)
  );

  instr_word_encoder #(.DEPTH(4), .ADDR_W(4), .BASE_ADDR(12)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .ins_type(ins_type), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .imm(imm), .err_clr(err_clr), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_instr(out_instr2), .out_addr(out_addr2),
    .count(count2), .err(err2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] t, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [12:0] im);
    ins_type = t; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
  endtask

  task automatic do_reset;
    in_valid = 1'b0; in_valid2 = 1'b0; out_ready = 1'b0; out_ready2 = 1'b0; err_clr = 1'b0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 0; in_valid2 = 0; out_ready = 0; out_ready2 = 0; err_clr = 0;
    ins_type = 0; rd = 0; rs1 = 0; rs2 = 0; funct3 = 0; funct7 = 0; imm = 0;
    #12;
    // reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_err", err, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_out_addr2", out_addr2, 4'hC);
    chk("rst_in_ready2", in_ready2, 1);
    chk("rst_err2", err2, 0);
    reset = 1'b0;

    // 1: single R-type
    drive(2'b00, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0);
    chk("t1_no_bypass", out_valid, 0);
    tick; in_valid = 0;
    chk("t1_valid", out_valid, 1);
    chk("t1_instr", out_instr, 32'h002081B3);
    chk("t1_addr", out_addr, 0);
    out_ready = 1; tick;
    chk("t1_empty", count, 0);
    chk("t1_instr_zero", out_instr, 0);
    chk("t1_addr_next", out_addr, 4);

    // 2: L, S, B back-to-back with consumer always ready
    do_reset; out_ready = 1;
    drive(2'b01, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 13'd8); tick;
    chk("t2_L_instr", out_instr, 32'h00812283);
    chk("t2_L_addr", out_addr, 10'h000);
    drive(2'b10, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 13'd12); tick;
    chk("t2_S_instr", out_instr, 32'h00512623);
    chk("t2_S_addr", out_addr, 10'h004);
    chk("t2_S_count", count, 1);
    drive(2'b11, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'h1FF8); tick;
    chk("t2_B_instr", out_instr, 32'hFE208CE3);
    chk("t2_B_addr", out_addr, 10'h008);
    in_valid = 0; tick;
    chk("t2_drained", count, 0);

    // 3: fill to DEPTH with consumer stalled, fifth word waits
    do_reset;
    drive(2'b00, 5'd1, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0); tick;
    rd = 5'd2; tick;
    rd = 5'd3; tick;
    chk("t3_ready_at3", in_ready, 1);
    rd = 5'd4; tick;
    chk("t3_full_count", count, 4);
    chk("t3_full_ready", in_ready, 0);
    rd = 5'd5; tick;
    chk("t3_stall_count", count, 4);
    chk("t3_hold_instr", out_instr, 32'h002080B3);
    chk("t3_hold_addr", out_addr, 0);
    out_ready = 1; tick;
    chk("t3_pop_full_count", count, 3);
    chk("t3_head2", out_instr, 32'h00208133);
    chk("t3_head2_addr", out_addr, 4);
    tick; in_valid = 0;
    chk("t3_pushpop_count", count, 3);
    chk("t3_head3", out_instr, 32'h002081B3);
    tick;
    chk("t3_head4", out_instr, 32'h00208233);
    tick;
    chk("t3_head5", out_instr, 32'h002082B3);
    chk("t3_head5_addr", out_addr, 16);
    tick;
    chk("t3_empty", out_valid, 0);

    // 4: illegal immediates dropped, sticky err, clear semantics
    do_reset;
    drive(2'b11, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'd5); tick;
    chk("t4_B_odd_count", count, 0);
    chk("t4_B_odd_err", err, 1);
    drive(2'b01, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 13'h0800); tick;
    in_valid = 0;
    chk("t4_L_big_count", count, 0);
    chk("t4_L_big_err", err, 1);
    err_clr = 1; tick; err_clr = 0;
    chk("t4_clr", err, 0);
    drive(2'b10, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 13'h1800); tick;
    in_valid = 0;
    chk("t4_S_min_err", err, 0);
    chk("t4_S_min_instr", out_instr, 32'h80512023);
    drive(2'b01, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 13'h17FF); err_clr = 1; tick;
    in_valid = 0; err_clr = 0;
    chk("t4_clr_vs_set", err, 1);
    chk("t4_clr_vs_set_count", count, 1);

    // 5: narrow address wraps modulo 16
    do_reset;
    drive(2'b00, 5'd1, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0);
    in_valid = 0; in_valid2 = 1;
    tick; tick; tick; in_valid2 = 0;
    chk("t5_count", count2, 3);
    chk("t5_addr0", out_addr2, 4'hC);
    out_ready2 = 1; tick;
    chk("t5_addr1", out_addr2, 4'h0);
    chk("t5_valid1", out_valid2, 1);
    tick;
    chk("t5_addr2", out_addr2, 4'h4);
    chk("t5_instr2", out_instr2, 32'h002080B3);
    out_ready2 = 0;

    // 6: asynchronous reset mid-handshake
    do_reset;
    drive(2'b00, 5'd1, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0); tick; tick; tick;
    chk("t6_count3", count, 3);
    out_ready = 1; #2; reset = 1; #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_count", count, 0);
    chk("t6_rst_ready", in_ready, 1);
    chk("t6_rst_addr", out_addr, 0);
    in_valid = 0; out_ready = 0; #1; reset = 0;
    drive(2'b00, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0); tick; in_valid = 0;
    chk("t6_post_instr", out_instr, 32'h002081B3);
    chk("t6_post_addr", out_addr, 0);
    chk("t6_post_count", count, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
